// File: rtl/mem_stage_wbuf_pkg.sv
// Shared opcodes and state encodings for the memory-access stage and its store buffer.
package mem_stage_wbuf_pkg;

  localparam logic [5:0] OP_LW = 6'h23;
  localparam logic [5:0] OP_SW = 6'h2b;

  localparam logic [0:0] D_IDLE = 1'b0;
  localparam logic [0:0] D_REQ  = 1'b1;

  localparam logic [1:0] L_IDLE = 2'd0;
  localparam logic [1:0] L_WAIT = 2'd1;
  localparam logic [1:0] L_REQ  = 2'd2;
  localparam logic [1:0] L_DONE = 2'd3;

endpackage

// File: rtl/mem_stage_wbuf_if.sv
// Data-memory port of the memory-access stage: single req/ack channel shared by
// store drains and loads. For reads, mem_rdata is valid in the cycle of mem_ack.
interface mem_stage_wbuf_if #(
  parameter int ADDR_W = 10
);
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic              mem_ack;
  logic [31:0]       mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_ack, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_ack, mem_rdata
  );
endinterface

// File: rtl/mem_stage_wbuf_fifo.sv
// Circular posted-store buffer with push/pop, occupancy and head outputs.
// With WBUF_FWD_EN defined it also searches for the youngest entry matching lookup_addr.
module mem_stage_wbuf_fifo #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 10
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic                    push,
  input  logic [ADDR_W-1:0]       push_addr,
  input  logic [31:0]             push_data,
  input  logic                    pop,
`ifdef WBUF_FWD_EN
  input  logic [ADDR_W-1:0]       lookup_addr,
  output logic                    hit,
  output logic [31:0]             hit_data,
`endif
  output logic [$clog2(DEPTH):0]  count,
  output logic [ADDR_W-1:0]       head_addr,
  output logic [31:0]             head_data
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [ADDR_W-1:0] addr_mem [DEPTH];
  logic [31:0]       data_mem [DEPTH];
  logic [PTR_W-1:0]  head;
  logic [PTR_W-1:0]  tail;

  // Pointers are exactly PTR_W bits wide, so wrap modulo DEPTH is free.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) tail <= tail + 1'b1;
      if (pop)  head <= head + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (push) begin
      addr_mem[tail] <= push_addr;
      data_mem[tail] <= push_data;
    end
  end

  assign head_addr = addr_mem[head];
  assign head_data = data_mem[head];

`ifdef WBUF_FWD_EN
  // Walk oldest to youngest so the last match seen is the youngest store.
  always_comb begin
    hit      = 1'b0;
    hit_data = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if ((CNT_W'(i) < count) && (addr_mem[head + PTR_W'(i)] == lookup_addr)) begin
        hit      = 1'b1;
        hit_data = data_mem[head + PTR_W'(i)];
      end
    end
  end
`endif

endmodule

// File: rtl/mem_stage_wbuf.sv
// Memory-access stage: posted store buffer drained over the memory port, loads ordered behind it.
// Optional store-to-load forwarding from the buffer when WBUF_FWD_EN is defined.
//
//   state  | meaning
//   D_IDLE | buffer empty, port free for loads
//   D_REQ  | writing head entry, held until mem_ack
//   L_IDLE | no load in flight
//   L_WAIT | load waiting for the store buffer to drain
//   L_REQ  | read request on the port, held until mem_ack
//   L_DONE | load data presented on Rdata for one cycle
module mem_stage_wbuf
  import mem_stage_wbuf_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 10
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic                    InsValid,
  input  logic [31:0]             Ins,
  input  logic [31:0]             Result,
  input  logic [31:0]             Rdata2,
  output logic [31:0]             Rdata,
  output logic                    stall,
  output logic                    wbuf_empty,
  mem_stage_wbuf_if.master        mem
);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic [CNT_W-1:0]  count;
  logic [CNT_W-1:0]  count_after;
  logic [ADDR_W-1:0] head_addr;
  logic [31:0]       head_data;
  logic [0:0]        d_state, d_next;
  logic [1:0]        l_state, l_next;
  logic [31:0]       load_data;
  logic              is_lw, is_sw, full, push, pop;
  logic              fwd_hit;
  logic [31:0]       fwd_data;
  logic              unused_bits;

  assign is_lw       = InsValid && (Ins[31:26] == OP_LW);
  assign is_sw       = InsValid && (Ins[31:26] == OP_SW);
  assign full        = (count == CNT_W'(DEPTH));
  assign push        = is_sw && !full;
  assign pop         = (d_state == D_REQ) && mem.mem_ack;
  assign count_after = count + CNT_W'(push) - CNT_W'(pop);
  assign wbuf_empty  = (count == '0);
  assign unused_bits = ^{Ins[25:0], Result[31:ADDR_W]};

  mem_stage_wbuf_fifo #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_fifo (
    .CLK        (CLK),
    .RST        (RST),
    .push       (push),
    .push_addr  (Result[ADDR_W-1:0]),
    .push_data  (Rdata2),
    .pop        (pop),
`ifdef WBUF_FWD_EN
    .lookup_addr(Result[ADDR_W-1:0]),
    .hit        (fwd_hit),
    .hit_data   (fwd_data),
`endif
    .count      (count),
    .head_addr  (head_addr),
    .head_data  (head_data)
  );

`ifndef WBUF_FWD_EN
  assign fwd_hit  = 1'b0;
  assign fwd_data = '0;
`endif

  always_comb begin
    d_next = d_state;
    if (d_state == D_IDLE) begin
      if (count != '0) d_next = D_REQ;
    end else if (pop && (count_after == '0)) begin
      d_next = D_IDLE;
    end
  end

  // Loads only leave L_WAIT once the drain is idle, so the port is never contended.
  always_comb begin
    l_next = l_state;
    case (l_state)
      L_IDLE:  if (is_lw && !fwd_hit) l_next = (count != '0) ? L_WAIT : L_REQ;
      L_WAIT:  if ((count == '0) && (d_state == D_IDLE)) l_next = L_REQ;
      L_REQ:   if (mem.mem_ack) l_next = L_DONE;
      L_DONE:  l_next = L_IDLE;
      default: l_next = L_IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      d_state   <= D_IDLE;
      l_state   <= L_IDLE;
      load_data <= '0;
    end else begin
      d_state <= d_next;
      l_state <= l_next;
      if ((l_state == L_REQ) && mem.mem_ack) load_data <= mem.mem_rdata;
    end
  end

  assign stall = (is_sw && full)
              || ((l_state == L_IDLE) && is_lw && !fwd_hit)
              || (l_state == L_WAIT)
              || (l_state == L_REQ);

  always_comb begin
    Rdata = Result;
    if (l_state == L_DONE)                           Rdata = load_data;
    else if ((l_state == L_IDLE) && is_lw && fwd_hit) Rdata = fwd_data;
  end

  // Port outputs decode straight from state so reset drops mem_req asynchronously.
  always_comb begin
    mem.mem_req   = 1'b0;
    mem.mem_we    = 1'b0;
    mem.mem_addr  = '0;
    mem.mem_wdata = '0;
    if (d_state == D_REQ) begin
      mem.mem_req   = 1'b1;
      mem.mem_we    = 1'b1;
      mem.mem_addr  = head_addr;
      mem.mem_wdata = head_data;
    end else if (l_state == L_REQ) begin
      mem.mem_req  = 1'b1;
      mem.mem_addr = Result[ADDR_W-1:0];
    end
  end

endmodule

// File: tb/tb_mem_stage_wbuf.sv
// Scoreboard bench for mem_stage_wbuf: stimulus queues expected write-back and memory
// transactions, a negedge monitor pops and compares them as the DUT presents them.
module tb_mem_stage_wbuf;
  import mem_stage_wbuf_pkg::*;

  localparam int DEPTH  = 4;
  localparam int ADDR_W = 10;
  localparam int BOUND  = 200;

  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [31:0]       data;
  } mem_txn_t;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        InsValid = 1'b0;
  logic [31:0] Ins = '0;
  logic [31:0] Result = '0;
  logic [31:0] Rdata2 = '0;
  logic [31:0] Rdata;
  logic        stall;
  logic        wbuf_empty;

  mem_stage_wbuf_if #(.ADDR_W(ADDR_W)) mem_bus();

  mem_stage_wbuf #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .CLK       (CLK),
    .RST       (RST),
    .InsValid  (InsValid),
    .Ins       (Ins),
    .Result    (Result),
    .Rdata2    (Rdata2),
    .Rdata     (Rdata),
    .stall     (stall),
    .wbuf_empty(wbuf_empty),
    .mem       (mem_bus)
  );

  always #5 CLK = ~CLK;

  int          n_cmp = 0;
  int          n_err = 0;
  logic [31:0] wb_q[$];
  mem_txn_t    mem_q[$];
  bit          ack_free = 1'b0;
  int          ack_budget = 0;
  int          ack_lat = 0;
  int          wait_cnt = 0;
  logic [31:0] mon_exp;
  mem_txn_t    mon_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Memory model: acks after ack_lat waiting cycles, only while acks are permitted.
  initial begin
    mem_bus.mem_ack   = 1'b0;
    mem_bus.mem_rdata = '0;
    forever begin
      @(posedge CLK);
      #2;
      if (mem_bus.mem_req && (ack_free || ack_budget > 0)) begin
        if (wait_cnt >= ack_lat) begin
          mem_bus.mem_ack = 1'b1;
          wait_cnt = 0;
          if (!ack_free) ack_budget--;
        end else begin
          mem_bus.mem_ack = 1'b0;
          wait_cnt++;
        end
      end else begin
        mem_bus.mem_ack = 1'b0;
        if (!mem_bus.mem_req) wait_cnt = 0;
      end
      mem_bus.mem_rdata = 32'hBEEF_0000 | 32'(mem_bus.mem_addr);
    end
  end

  always @(negedge CLK) begin
    if (!RST) begin
      if (InsValid && !stall) begin
        if (wb_q.size() == 0) begin
          n_cmp++; n_err++;
          $display("FAIL wb_unexpected: got Rdata %h with no expected retire", Rdata);
        end else begin
          mon_exp = wb_q.pop_front();
          chk("wb_rdata", Rdata, mon_exp);
        end
      end
      if (mem_bus.mem_req && mem_bus.mem_ack) begin
        if (mem_q.size() == 0) begin
          n_cmp++; n_err++;
          $display("FAIL mem_unexpected: got we=%b addr=%h with none expected",
                   mem_bus.mem_we, mem_bus.mem_addr);
        end else begin
          mon_t = mem_q.pop_front();
          chk("mem_we", {31'b0, mem_bus.mem_we}, {31'b0, mon_t.we});
          chk("mem_addr", 32'(mem_bus.mem_addr), 32'(mon_t.addr));
          if (mon_t.we) chk("mem_wdata", mem_bus.mem_wdata, mon_t.data);
          else          chk("rd_after_drain", {31'b0, wbuf_empty}, 32'd1);
        end
      end
    end
  end

  task automatic set_ins(input logic [5:0] op, input logic [31:0] res, input logic [31:0] d2,
                         input logic [31:0] exp_wb, input bit exp_rd);
    InsValid = 1'b1;
    Ins      = {op, 26'h0};
    Result   = res;
    Rdata2   = d2;
    wb_q.push_back(exp_wb);
    if (op == OP_SW)                mem_q.push_back({1'b1, res[ADDR_W-1:0], d2});
    else if (op == OP_LW && exp_rd) mem_q.push_back({1'b0, res[ADDR_W-1:0], 32'h0});
  endtask

  task automatic wait_accept(input string name, input int exp_first);
    int cyc = 0;
    bit done = 1'b0;
    while (!done) begin
      @(negedge CLK);
      if (cyc == 0 && exp_first >= 0) chk(name, {31'b0, stall}, exp_first);
      if (!stall) done = 1'b1;
      else begin
        cyc++;
        if (cyc >= BOUND) begin
          n_cmp++; n_err++;
          $display("FAIL %s_timeout: stall still 1 after %0d cycles", name, cyc);
          done = 1'b1;
        end
      end
    end
    @(posedge CLK);
    #1;
    InsValid = 1'b0;
  endtask

  task automatic issue(input logic [5:0] op, input logic [31:0] res, input logic [31:0] d2,
                       input logic [31:0] exp_wb, input bit exp_rd, input string name,
                       input int exp_first);
    set_ins(op, res, d2, exp_wb, exp_rd);
    wait_accept(name, exp_first);
  endtask

  task automatic wait_empty(input string name);
    int cyc = 0;
    do begin
      @(negedge CLK);
      cyc++;
    end while (!(wbuf_empty && !mem_bus.mem_req) && cyc < BOUND);
    chk(name, {31'b0, wbuf_empty}, 32'd1);
    @(posedge CLK);
    #1;
  endtask

  task automatic idle(input int n);
    InsValid = 1'b0;
    repeat (n) begin
      @(posedge CLK);
      #1;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    repeat (2) @(posedge CLK);
    #1;
    Result = 32'h55;
    @(negedge CLK);
    chk("rst_stall", {31'b0, stall}, 32'd0);
    chk("rst_req", {31'b0, mem_bus.mem_req}, 32'd0);
    chk("rst_we", {31'b0, mem_bus.mem_we}, 32'd0);
    chk("rst_addr", 32'(mem_bus.mem_addr), 32'd0);
    chk("rst_wdata", mem_bus.mem_wdata, 32'd0);
    chk("rst_empty", {31'b0, wbuf_empty}, 32'd1);
    chk("rst_rdata", Rdata, 32'h55);
    @(posedge CLK);
    #1;
    RST = 1'b0;

    // pass-through of a non-memory op
    issue(6'h00, 32'h7, 32'h0, 32'h7, 1'b0, "pass_stall", 0);
    @(negedge CLK);
    chk("pass_no_req", {31'b0, mem_bus.mem_req}, 32'd0);
    @(posedge CLK);
    #1;

    // an SW without InsValid is not enqueued
    Ins = {OP_SW, 26'h0};
    Result = 32'h9;
    idle(3);
    @(negedge CLK);
    chk("novalid_empty", {31'b0, wbuf_empty}, 32'd1);
    chk("novalid_req", {31'b0, mem_bus.mem_req}, 32'd0);
    @(posedge CLK);
    #1;

    // reset while a drain is pending with 3 entries
    for (int i = 1; i <= 3; i++)
      issue(OP_SW, 32'h100 + 32'(i), 32'hC0 + 32'(i), 32'h100 + 32'(i), 1'b0, "rstmid_sw", 0);
    idle(2);
    @(negedge CLK);
    chk("rstmid_req_before", {31'b0, mem_bus.mem_req}, 32'd1);
    @(posedge CLK);
    #3;
    RST = 1'b1;
    #1;
    chk("rstmid_req_async", {31'b0, mem_bus.mem_req}, 32'd0);
    mem_q.delete();
    @(posedge CLK);
    #1;
    RST = 1'b0;
    @(negedge CLK);
    chk("rstmid_empty", {31'b0, wbuf_empty}, 32'd1);
    chk("rstmid_stall", {31'b0, stall}, 32'd0);
    @(posedge CLK);
    #1;

    // fill: 4 stores accepted, 5th stalls, one ack frees it a cycle later
    for (int i = 1; i <= 4; i++)
      issue(OP_SW, 32'(i), 32'hA0 + 32'(i), 32'(i), 1'b0, "fill_sw", 0);
    set_ins(OP_SW, 32'h5, 32'hA5, 32'h5, 1'b0);
    @(negedge CLK);
    chk("fill_full_stall", {31'b0, stall}, 32'd1);
    ack_budget = 1;
    @(negedge CLK);
    chk("fill_ack_still_stall", {31'b0, stall}, 32'd1);
    chk("fill_ack_seen", {31'b0, mem_bus.mem_ack}, 32'd1);
    @(negedge CLK);
    chk("fill_release", {31'b0, stall}, 32'd0);
    @(posedge CLK);
    #1;
    InsValid = 1'b0;
    ack_free = 1'b1;
    wait_empty("fill_drain");
    ack_free = 1'b0;

    // load behind a store with 2-cycle ack latency
    ack_free = 1'b1;
    ack_lat  = 2;
    issue(OP_SW, 32'h10, 32'hDEAD, 32'h10, 1'b0, "ld_sw", 0);
    issue(OP_LW, 32'h20, 32'h0, 32'hBEEF_0020, 1'b1, "ld_first_stall", 1);
    wait_empty("ld_drain");
    ack_lat  = 0;

    // minimum load latency: two stalled cycles, released in the third
    set_ins(OP_LW, 32'h33, 32'h0, 32'hBEEF_0033, 1'b1);
    @(negedge CLK);
    chk("lwmin_c0", {31'b0, stall}, 32'd1);
    @(negedge CLK);
    chk("lwmin_c1", {31'b0, stall}, 32'd1);
    @(negedge CLK);
    chk("lwmin_c2", {31'b0, stall}, 32'd0);
    @(posedge CLK);
    #1;
    InsValid = 1'b0;
    ack_free = 1'b0;

    // two stores to one address, then a load of it with acks held off
    issue(OP_SW, 32'h10, 32'h1111, 32'h10, 1'b0, "fwd_sw1", 0);
    issue(OP_SW, 32'h10, 32'h2222, 32'h10, 1'b0, "fwd_sw2", 0);
`ifdef WBUF_FWD_EN
    issue(OP_LW, 32'h10, 32'h0, 32'h2222, 1'b0, "fwd_hit_nostall", 0);
`else
    set_ins(OP_LW, 32'h10, 32'h0, 32'hBEEF_0010, 1'b1);
    @(negedge CLK);
    chk("nofwd_stall", {31'b0, stall}, 32'd1);
    ack_free = 1'b1;
    wait_accept("nofwd_wait", -1);
`endif
    ack_free = 1'b1;
    wait_empty("fwd_drain");
    ack_free = 1'b0;

    // enqueue and drain ack in the same cycle at count==DEPTH-1
    for (int i = 0; i < 3; i++)
      issue(OP_SW, 32'h40 + 32'(i), 32'h5000 + 32'(i), 32'h40 + 32'(i), 1'b0, "sim_pre", 0);
    idle(2);
    ack_budget = 1;
    issue(OP_SW, 32'h43, 32'h5003, 32'h43, 1'b0, "sim_push", 0);
    issue(OP_SW, 32'h44, 32'h5004, 32'h44, 1'b0, "sim_count_kept", 0);
    set_ins(OP_SW, 32'h45, 32'h5005, 32'h45, 1'b0);
    @(negedge CLK);
    chk("sim_full", {31'b0, stall}, 32'd1);
    ack_free = 1'b1;
    wait_accept("sim_full_wait", -1);
    wait_empty("sim_drain");
    ack_free = 1'b0;

    idle(2);
    chk("wb_q_left", 32'(wb_q.size()), 32'd0);
    chk("mem_q_left", 32'(mem_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
